// File: rtl/lfsr_hex_gen.sv
// Maximal-length Fibonacci LFSR with prescaled free-run or manual stepping,
// seed load, and an active-low seven-segment view of the low STATE nibbles.
module lfsr_hex_gen #(
  parameter int               WIDTH     = 16,
  parameter int               DIGITS    = 2,
  parameter int               DIV       = 50000000,
  parameter logic [WIDTH-1:0] SEED_INIT = 16'hACE1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  input  logic                STEP,
  input  logic                LOAD,
  input  logic [WIDTH-1:0]    SEED,
  output logic [DIGITS*7-1:0] HEX,
  output logic                NEW,
  output logic [WIDTH-1:0]    STATE
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [31:0] TAPS = (WIDTH == 8)  ? 32'h0000_00B8 :
                                 (WIDTH == 16) ? 32'h0000_D008 :
                                 (WIDTH == 24) ? 32'h00E1_0000 :
                                                 32'h8020_0003;

  typedef enum logic {MANUAL = 1'b0, RUN = 1'b1} fsm_t;

  fsm_t                r_fsm;
  logic [CW-1:0]       r_cnt;
  logic [WIDTH-1:0]    r_lfsr;
  logic                r_upd;
  logic [DIGITS*4-1:0] r_disp;
  logic                r_new;

  logic [CW-1:0]       w_cnt_base;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_tick;
  logic                w_step;
  logic                w_fb;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // Entering RUN the count restarts from 0, so the first tick lands DIV edges later.
  always_comb begin
    w_cnt_base = (r_fsm == MANUAL) ? '0 : r_cnt;
    w_tick     = EN && (w_cnt_base == CNT_LAST);
    w_cnt_nxt  = (!EN || LOAD || w_tick) ? '0 : w_cnt_base + CW'(1);
    w_step     = !LOAD && (EN ? w_tick : STEP);
    w_fb       = ^(r_lfsr & TAPS[WIDTH-1:0]);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_fsm <= MANUAL;
      r_cnt <= '0;
    end else begin
      r_fsm <= EN ? RUN : MANUAL;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_lfsr <= SEED_INIT;
      r_upd  <= 1'b0;
    end else begin
      r_upd <= LOAD || w_step || (r_lfsr == '0);
      if (r_lfsr == '0)
        r_lfsr <= WIDTH'(1);
      else if (LOAD)
        r_lfsr <= (SEED == '0) ? WIDTH'(1) : SEED;
      else if (w_step)
        r_lfsr <= {r_lfsr[WIDTH-2:0], w_fb};
    end
  end

  // Display stage: follows the LFSR by one cycle, NEW marks the refresh.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_disp <= '0;
      r_new  <= 1'b0;
    end else begin
      r_new <= r_upd;
      if (r_upd)
        r_disp <= r_lfsr[DIGITS*4-1:0];
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_seg
    assign HEX[7*k +: 7] = seg7(r_disp[4*k +: 4]);
  end

  assign NEW   = r_new;
  assign STATE = r_lfsr;

endmodule

// File: tb/tb_lfsr_hex_gen.sv
// Directed bench for lfsr_hex_gen: 16-bit instance (DIV=4) for stepping,
// load and reset behaviour, 8-bit instance for the full-period walk.
module tb_lfsr_hex_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_en, a_step, a_load, a_new;
  logic [15:0] a_seed, a_state;
  logic [13:0] a_hex;

  logic        b_rst_n, b_en, b_step, b_load, b_new;
  logic [7:0]  b_seed, b_state;
  logic [13:0] b_hex;

  int checks = 0;
  int failures = 0;
  int new_cnt;
  int early;

  lfsr_hex_gen #(.WIDTH(16), .DIGITS(2), .DIV(4), .SEED_INIT(16'h0001)) u_a (
    .CLK(clk), .RST_N(a_rst_n), .EN(a_en), .STEP(a_step), .LOAD(a_load),
    .SEED(a_seed), .HEX(a_hex), .NEW(a_new), .STATE(a_state)
  );

  lfsr_hex_gen #(.WIDTH(8), .DIGITS(2), .DIV(4), .SEED_INIT(8'h01)) u_b (
    .CLK(clk), .RST_N(b_rst_n), .EN(b_en), .STEP(b_step), .LOAD(b_load),
    .SEED(b_seed), .HEX(b_hex), .NEW(b_new), .STATE(b_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    a_rst_n = 1'b0; a_en = 1'b0; a_step = 1'b0; a_load = 1'b0; a_seed = '0;
    b_rst_n = 1'b0; b_en = 1'b0; b_step = 1'b0; b_load = 1'b0; b_seed = '0;
    cyc(2);
    chk("rst_state", 32'(a_state), 32'h0001);
    chk("rst_hex",   32'(a_hex),   32'({7'h40, 7'h40}));
    chk("rst_new",   32'(a_new),   32'h0);

    // free-run from reset release
    a_rst_n = 1'b1; b_rst_n = 1'b1; a_en = 1'b1;
    cyc(3);
    chk("run_edge3_state", 32'(a_state), 32'h0001);
    cyc(1);
    chk("run_edge4_state", 32'(a_state), 32'h0002);
    chk("run_edge4_new",   32'(a_new),   32'h0);
    cyc(1);
    chk("run_new_pulse", 32'(a_new),      32'h1);
    chk("run_hex0",      32'(a_hex[6:0]), 32'h24);
    chk("run_hex1",      32'(a_hex[13:7]),32'h40);
    cyc(1);
    chk("run_new_single", 32'(a_new), 32'h0);
    cyc(1);
    chk("run_edge7_state", 32'(a_state), 32'h0002);
    cyc(1);
    chk("run_edge8_state", 32'(a_state), 32'h0004);

    // STEP while EN=1 must be ignored
    a_step = 1'b1;
    cyc(1);
    chk("run_step_ignored", 32'(a_state), 32'h0004);
    chk("run_step_new",     32'(a_new),   32'h1);

    // LOAD of zero with a simultaneous STEP
    a_en = 1'b0; a_load = 1'b1; a_seed = 16'h0000; a_step = 1'b1;
    cyc(1);
    chk("load0_state", 32'(a_state), 32'h0001);
    a_load = 1'b0; a_step = 1'b0;
    cyc(1);
    chk("load0_new",  32'(a_new),      32'h1);
    chk("load0_hex0", 32'(a_hex[6:0]), 32'h79);
    chk("load0_state_hold", 32'(a_state), 32'h0001);

    // three manual STEP pulses
    new_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      a_step = (i < 6) && (i % 2 == 0);
      cyc(1);
      if (a_new) new_cnt++;
    end
    a_step = 1'b0;
    chk("man_state",   32'(a_state),    32'h0008);
    chk("man_new_cnt", 32'(new_cnt),    32'd3);
    chk("man_hex0",    32'(a_hex[6:0]), 32'h00);

    // LOAD 0xBEEF: low byte EF shows E on digit 1 and F on digit 0
    a_load = 1'b1; a_seed = 16'hBEEF;
    cyc(1);
    chk("beef_state", 32'(a_state), 32'hBEEF);
    a_load = 1'b0;
    cyc(1);
    chk("beef_new",  32'(a_new),       32'h1);
    chk("beef_hex0", 32'(a_hex[6:0]),  32'h0E);
    chk("beef_hex1", 32'(a_hex[13:7]), 32'h06);

    // reset pulsed with the prescaler at 2
    a_en = 1'b1;
    cyc(2);
    a_rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(a_state), 32'h0001);
    chk("midrst_hex",   32'(a_hex),   32'({7'h40, 7'h40}));
    chk("midrst_new",   32'(a_new),   32'h0);
    cyc(1);
    a_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("postrst_no_new", 32'(a_new), 32'h0);
    end
    chk("postrst_state", 32'(a_state), 32'h0001);

    // 8-bit full period walk from 0x01
    early = 0;
    b_step = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      cyc(1);
      if (i < 255 && b_state == 8'h01) early++;
    end
    b_step = 1'b0;
    chk("period_no_early", 32'(early),   32'd0);
    chk("period_255",      32'(b_state), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
